// File: rtl/display_pkg.sv
// Digit codes and elaboration helpers shared by the display path and seg7_control.
package display_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_BLANK = 4'hF;
    localparam digit_t DIG_MINUS = 4'hA;

    function automatic int clog2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Decimal digits needed for an unsigned value of the given bit width (log10(2) ~ 0.30103).
    function automatic int bcd_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bcd_shift_add.sv
// Iterative double-dabble: one add-3-then-shift step per clock, DATA_W steps after start.
module bcd_shift_add
    import display_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BCD_DIGITS = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin_in,
    output logic [4*BCD_DIGITS-1:0] bcd_out,
    output logic                    done
);
    localparam int CNT_W = clog2(DATA_W + 1);

    logic [DATA_W-1:0]       bin_q, bin_d;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
    logic [4*BCD_DIGITS-1:0] adj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    run_q, run_d;
    logic                    done_q, done_d;

    for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
        digit_t dig;
        assign dig = bcd_q[4*gi +: 4];
        assign adj[4*gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end

    always_comb begin
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            bin_d = bin_in;
            bcd_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            bcd_d = {adj[4*BCD_DIGITS-2:0], bin_q[DATA_W-1]};
            bin_d = {bin_q[DATA_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_W - 1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign bcd_out = bcd_q;
    assign done    = done_q;

endmodule

// File: rtl/display_formatter.sv
// Signed result -> blanked, sign-prefixed, paged BCD digit string for the seg7 mux.
// Build option AUTO_SCROLL_EN: ignore page_sel and cycle pages every SCROLL_TICKS clocks.
module display_formatter
    import display_pkg::*;
#(
    parameter int  DATA_W       = 32,
    parameter int  NUM_DIGITS   = 4,
    parameter int  SCROLL_TICKS = 100_000_000,
    localparam int BCD_DIGITS   = bcd_digits(DATA_W),
    localparam int SLOTS        = BCD_DIGITS + 1,
    localparam int PAGES        = (SLOTS + NUM_DIGITS - 1) / NUM_DIGITS,
    localparam int PAGE_W       = (clog2(PAGES) < 1) ? 1 : clog2(PAGES),
    localparam int DOT_W        = clog2(BCD_DIGITS + 1)
) (
    input  logic                    CLK100MHz,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       result_in,
    input  logic [DOT_W-1:0]        dot_pos,
    input  logic [PAGE_W-1:0]       page_sel,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [2:0]              dot_out,
    output logic                    sign_out,
    output logic [PAGE_W-1:0]       num_pages,
    output logic                    out_valid,
    output logic                    busy
);
    localparam int SLOT_CNT = PAGES * NUM_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FORMAT} state_t;

    state_t                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic [DOT_W-1:0]        dot_pos_q, dot_pos_d;
    logic [4*SLOT_CNT-1:0]   slots_q, slots_d;
    logic [PAGE_W-1:0]       num_pages_q, num_pages_d;
    logic                    csign_q, csign_d;
    logic [DOT_W-1:0]        cdot_q, cdot_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [2:0]              dot_out_q, dot_out_d;
    logic                    out_valid_q, out_valid_d;

    logic                    accept, commit, conv_done;
    logic [DATA_W-1:0]       magnitude;
    logic [4*BCD_DIGITS-1:0] bcd;
    logic [4*SLOT_CNT-1:0]   fmt_slots;
    logic [PAGE_W-1:0]       page_req;
    int                      sig_n, dot_i, fill_top, fmt_pages, pg_i, cdot_i;

    assign accept    = in_valid && (state_q == S_IDLE);
    assign commit    = (state_q == S_FORMAT);
    assign magnitude = result_in[DATA_W-1] ? (~result_in + DATA_W'(1)) : result_in;

    bcd_shift_add #(
        .DATA_W     (DATA_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_bcd (
        .clk     (CLK100MHz),
        .rst_n   (reset_n),
        .start   (accept),
        .bin_in  (magnitude),
        .bcd_out (bcd),
        .done    (conv_done)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        dot_pos_d = dot_pos_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sign_d    = result_in[DATA_W-1];
                    dot_pos_d = dot_pos;
                    state_d   = S_CONVERT;
                end
            end
            S_CONVERT: if (conv_done) state_d = S_FORMAT;
            S_FORMAT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Digits below fill_top come straight from BCD: above the MSD they are zero,
    // which gives the forced zeros between the value and a high dot position.
    always_comb begin
        fmt_slots = {SLOT_CNT{DIG_BLANK}};
        sig_n     = 1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] != 4'd0) sig_n = i + 1;
        end
        dot_i    = (int'(dot_pos_q) > BCD_DIGITS) ? BCD_DIGITS : int'(dot_pos_q);
        fill_top = (dot_i > sig_n) ? dot_i : sig_n;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (i < fill_top) fmt_slots[4*i +: 4] = bcd[4*i +: 4];
        end
        if (sign_q) fmt_slots[4*fill_top +: 4] = DIG_MINUS;
        fmt_pages = (fill_top + (sign_q ? 1 : 0) + NUM_DIGITS - 1) / NUM_DIGITS;
    end

`ifdef AUTO_SCROLL_EN
    localparam int TICK_W = (clog2(SCROLL_TICKS) < 1) ? 1 : clog2(SCROLL_TICKS);

    logic [TICK_W-1:0] tick_q, tick_d;
    logic [PAGE_W-1:0] scroll_q, scroll_d;

    always_comb begin
        tick_d   = tick_q + TICK_W'(1);
        scroll_d = scroll_q;
        if (commit) begin
            tick_d   = '0;
            scroll_d = '0;
        end else if (tick_q == TICK_W'(SCROLL_TICKS - 1)) begin
            tick_d   = '0;
            scroll_d = (scroll_q >= num_pages_q - PAGE_W'(1)) ? '0 : scroll_q + PAGE_W'(1);
        end
    end

    always_ff @(posedge CLK100MHz or negedge reset_n) begin
        if (!reset_n) begin
            tick_q   <= '0;
            scroll_q <= '0;
        end else begin
            tick_q   <= tick_d;
            scroll_q <= scroll_d;
        end
    end

    assign page_req = scroll_d;
`else
    assign page_req = page_sel;
`endif

    // Output registers look at the value being committed this cycle, so the
    // new digits appear together with out_valid.
    always_comb begin
        slots_d     = commit ? fmt_slots : slots_q;
        num_pages_d = commit ? PAGE_W'(fmt_pages) : num_pages_q;
        csign_d     = commit ? sign_q : csign_q;
        cdot_d      = commit ? dot_pos_q : cdot_q;
        out_valid_d = commit;

        pg_i = int'(page_req);
        if (pg_i > int'(num_pages_d) - 1) pg_i = int'(num_pages_d) - 1;
        digits_d = slots_d[4*NUM_DIGITS*pg_i +: 4*NUM_DIGITS];

        cdot_i    = int'(cdot_d);
        dot_out_d = 3'd0;
        if (cdot_i != 0 && cdot_i - 1 >= pg_i * NUM_DIGITS && cdot_i - 1 < (pg_i + 1) * NUM_DIGITS)
            dot_out_d = 3'(cdot_i - pg_i * NUM_DIGITS);
    end

    always_ff @(posedge CLK100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            dot_pos_q   <= '0;
            slots_q     <= {SLOT_CNT{DIG_BLANK}};
            num_pages_q <= PAGE_W'(1);
            csign_q     <= 1'b0;
            cdot_q      <= '0;
            digits_q    <= {NUM_DIGITS{DIG_BLANK}};
            dot_out_q   <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            dot_pos_q   <= dot_pos_d;
            slots_q     <= slots_d;
            num_pages_q <= num_pages_d;
            csign_q     <= csign_d;
            cdot_q      <= cdot_d;
            digits_q    <= digits_d;
            dot_out_q   <= dot_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign digits_out = digits_q;
    assign dot_out    = dot_out_q;
    assign sign_out   = csign_q;
    assign num_pages  = num_pages_q;
    assign out_valid  = out_valid_q;

endmodule
